// File: rtl/prio_enc_queue.sv
`default_nettype none
// ============================================================================
// prio_enc_queue : captures N one-cycle request pulses into a pending set and
// issues them one at a time as binary indices on a valid/ready port.
// Build option: define PRIO_ENC_RR_EN for a round-robin pick (default is
// fixed highest-index priority).
// Revision: 1.0
// ============================================================================
module prio_enc_queue #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  output logic [W-1:0] idx_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   pend_cnt,
  output logic         dup_err
);

  localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;
  logic [W:0]   cnt_q, cnt_d;
  logic         dup_q, dup_d;

  logic [N-1:0] w_cand;
  logic         w_load;
  logic [W-1:0] w_pick;

  assign w_cand = pending_q | req_in;
  assign w_load = !valid_q || out_ready;

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] ptr_q, ptr_d;

  // First set bit at or above ptr, wrapping from N-1 back to 0.
  always_comb begin
    logic found;
    int   j;
    w_pick = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!found && w_cand[j]) begin
        w_pick = W'(j);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (w_load && (|w_cand)) begin
      ptr_d = (w_pick == W'(N - 1)) ? '0 : w_pick + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Ascending scan, so the last match is the highest set index.
  always_comb begin
    w_pick = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand[i]) w_pick = W'(i);
    end
  end
`endif

  always_comb begin
    pending_d = w_cand;
    idx_d     = idx_q;
    valid_d   = valid_q;
    if (w_load) begin
      if (|w_cand) begin
        idx_d     = w_pick;
        valid_d   = 1'b1;
        pending_d = w_cand & ~(C_ONE << w_pick);
      end else begin
        valid_d   = 1'b0;
        pending_d = '0;
      end
    end
  end

  // Only bits already waiting count as duplicates; the held output index does not.
  assign dup_d = |(pending_q & req_in);

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d = cnt_d + (W + 1)'(pending_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      dup_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      dup_q     <= dup_d;
    end
  end

  assign idx_out   = idx_q;
  assign out_valid = valid_q;
  assign pend_cnt  = cnt_q;
  assign dup_err   = dup_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_enc_queue.sv
`default_nettype none
// ============================================================================
// tb_prio_enc_queue : directed self-checking bench for prio_enc_queue (N=8).
// Revision: 1.0
// ============================================================================
module tb_prio_enc_queue;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_in;
  logic [W-1:0] idx_out;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   pend_cnt;
  logic         dup_err;

  int passed = 0;
  int total  = 0;

  prio_enc_queue #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .idx_out   (idx_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pend_cnt  (pend_cnt),
    .dup_err   (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] idx,
                         input logic [W:0] cnt);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, ".idx"}, 32'(idx_out), 32'(idx));
    chk({tag, ".cnt"}, 32'(pend_cnt), 32'(cnt));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_in    = 8'hFF;
    out_ready = 1'b1;

    // Reset held with all requests asserted
    tick();
    tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.idx",   32'(idx_out),   32'd0);
    chk("rst.cnt",   32'(pend_cnt),  32'd0);
    chk("rst.dup",   32'(dup_err),   32'd0);

    rst_n  = 1'b1;
    req_in = 8'h00;
    tick();
    chk_out("rel", 1'b0, 3'd0, 4'd0);

    // Single event
    req_in = 8'h20;
    tick();
    req_in = 8'h00;
    chk_out("single", 1'b1, 3'd5, 4'd0);
    tick();
    chk_out("single.end", 1'b0, 3'd0, 4'd0);

    // Burst drain: 7, 3, 1 with pend_cnt 2, 1, 0
    req_in = 8'h8A;
    tick();
    req_in = 8'h00;
`ifdef PRIO_ENC_RR_EN
    // ptr is 6 after issuing 5: order 7, 1, 3
    chk_out("burst0", 1'b1, 3'd7, 4'd2);
    tick();
    chk_out("burst1", 1'b1, 3'd1, 4'd1);
    tick();
    chk_out("burst2", 1'b1, 3'd3, 4'd0);
`else
    chk_out("burst0", 1'b1, 3'd7, 4'd2);
    tick();
    chk_out("burst1", 1'b1, 3'd3, 4'd1);
    tick();
    chk_out("burst2", 1'b1, 3'd1, 4'd0);
`endif
    tick();
    chk_out("burst.end", 1'b0, 3'd0, 4'd0);

    // Stall: index 2 issued then held; a repeat of the held index is a new event
    out_ready = 1'b0;
    req_in    = 8'h04;
    tick();
    req_in = 8'h00;
    chk_out("stall0", 1'b1, 3'd2, 4'd0);
    chk("stall0.dup", 32'(dup_err), 32'd0);
    tick();
    chk_out("stall1", 1'b1, 3'd2, 4'd0);
    req_in = 8'h04;
    tick();
    req_in = 8'h00;
    chk_out("stall2", 1'b1, 3'd2, 4'd1);
    chk("stall2.dup", 32'(dup_err), 32'd0);
    // Another pulse on the now-pending bit merges and flags a duplicate
    req_in = 8'h04;
    tick();
    req_in = 8'h00;
    chk_out("dup", 1'b1, 3'd2, 4'd1);
    chk("dup.pulse", 32'(dup_err), 32'd1);
    tick();
    chk("dup.clear", 32'(dup_err), 32'd0);
    out_ready = 1'b1;
    tick();
    chk_out("reissue", 1'b1, 3'd2, 4'd0);
    tick();
    chk_out("reissue.end", 1'b0, 3'd0, 4'd0);

    // Fresh reset so the pick pointer starts at 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_out("rst2", 1'b0, 3'd0, 4'd0);

    // Held 8'h11: round-robin alternates 0/4, fixed always 4
    req_in = 8'h11;
`ifdef PRIO_ENC_RR_EN
    tick();
    chk_out("rr0", 1'b1, 3'd0, 4'd1);
    tick();
    chk_out("rr1", 1'b1, 3'd4, 4'd1);
    tick();
    chk_out("rr2", 1'b1, 3'd0, 4'd1);
    tick();
    chk_out("rr3", 1'b1, 3'd4, 4'd1);
`else
    tick();
    chk_out("fx0", 1'b1, 3'd4, 4'd1);
    chk("fx0.dup", 32'(dup_err), 32'd0);
    tick();
    chk_out("fx1", 1'b1, 3'd4, 4'd1);
    chk("fx1.dup", 32'(dup_err), 32'd1);
    tick();
    chk_out("fx2", 1'b1, 3'd4, 4'd1);
    tick();
    chk_out("fx3", 1'b1, 3'd4, 4'd1);
`endif
    req_in = 8'h00;

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Asynchronous reset mid-operation with three pending
    out_ready = 1'b0;
    req_in    = 8'h0F;
    tick();
    req_in = 8'h00;
`ifdef PRIO_ENC_RR_EN
    chk_out("pre", 1'b1, 3'd0, 4'd3);
`else
    chk_out("pre", 1'b1, 3'd3, 4'd3);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.valid", 32'(out_valid), 32'd0);
    chk("async.idx",   32'(idx_out),   32'd0);
    chk("async.cnt",   32'(pend_cnt),  32'd0);
    chk("async.dup",   32'(dup_err),   32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk_out("post.idle", 1'b0, 3'd0, 4'd0);
    req_in = 8'h02;
    tick();
    req_in = 8'h00;
    chk_out("post.first", 1'b1, 3'd1, 4'd0);
    tick();
    chk_out("post.end", 1'b0, 3'd0, 4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
